// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming(7,4) receive path.
//   POS_P1..POS_M3 : codeword bit positions, in transmission order (1 is sent first)
//   codeword_t     : 7-bit codeword, indexed by position [7:1]
//   nibble_t       : 4-bit payload {m3,m2,m1,m0}
//   rx_state_t     : receive framing FSM states
package hamming_pkg;

  localparam int unsigned POS_P1 = 1;
  localparam int unsigned POS_P2 = 2;
  localparam int unsigned POS_M0 = 3;
  localparam int unsigned POS_P3 = 4;
  localparam int unsigned POS_M1 = 5;
  localparam int unsigned POS_M2 = 6;
  localparam int unsigned POS_M3 = 7;

  typedef logic [7:1] codeword_t;
  typedef logic [3:0] nibble_t;

  typedef enum logic {
    IDLE,
    SHIFT
  } rx_state_t;

endpackage

// File: rtl/hamming_syndrome_fix.sv
// Combinational Hamming(7,4) syndrome computation and single-bit correction.
//   cw       : received codeword, positions [7:1]
//   data     : corrected payload {m3,m2,m1,m0}
//   syndrome : {s3,s2,s1}; non-zero value is the position that was inverted
module hamming_syndrome_fix
  import hamming_pkg::*;
(
  input  codeword_t  cw,
  output nibble_t    data,
  output logic [2:0] syndrome
);

  codeword_t fixed;

  always_comb begin
    syndrome[0] = cw[1] ^ cw[3] ^ cw[5] ^ cw[7];
    syndrome[1] = cw[2] ^ cw[3] ^ cw[6] ^ cw[7];
    syndrome[2] = cw[4] ^ cw[5] ^ cw[6] ^ cw[7];
    fixed = cw;
    // A syndrome pointing at a parity position flips a bit that is not
    // extracted below, so the payload passes through unchanged.
    if (syndrome != 3'd0) begin
      fixed[syndrome] = ~cw[syndrome];
    end
    data = {fixed[POS_M3], fixed[POS_M2], fixed[POS_M1], fixed[POS_M0]};
  end

endmodule

// File: rtl/hamming_rx_corrector.sv
// Serial Hamming(7,4) receiver: deserialises one codeword per frame,
// corrects single-bit errors and presents the nibble on a valid/ready
// output register, with a saturating count of corrected frames.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_bit/in_valid/in_sof: serial input; in_sof marks codeword position 1
//   in_ready              : input accepted this cycle
//   out_data/out_syndrome/out_err/out_valid/out_ready : output register handshake
//   clr_count             : synchronous clear of err_count (wins over increment)
//   err_count             : saturating count of frames loaded with out_err=1
module hamming_rx_corrector
  import hamming_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output nibble_t          out_data,
  output logic [2:0]       out_syndrome,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_count,
  output logic [CNT_W-1:0] err_count
);

  rx_state_t  state, state_nxt;
  logic [2:0] bit_cnt;
  codeword_t  sr;
  codeword_t  cw_full;
  nibble_t    fix_data;
  logic [2:0] fix_syn;
  logic       beat, sof_beat, done;

  // Position 7 comes straight from the input so correction happens in the
  // same cycle as the completing beat.
  always_comb begin
    cw_full = {in_bit, sr[6:1]};
  end

  hamming_syndrome_fix u_fix (
    .cw       (cw_full),
    .data     (fix_data),
    .syndrome (fix_syn)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (sof_beat) state_nxt = SHIFT;
      SHIFT: if (done)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready = !(state == SHIFT && bit_cnt == 3'd6 && out_valid && !out_ready);
    beat     = in_valid && in_ready;
    sof_beat = beat && in_sof;
    done     = beat && !in_sof && state == SHIFT && bit_cnt == 3'd6;
  end

  // Shift register and position counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      sr      <= '0;
    end else if (sof_beat) begin
      sr      <= {6'd0, in_bit};
      bit_cnt <= 3'd1;
    end else if (beat && state == SHIFT) begin
      if (done) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else begin
        sr[bit_cnt + 3'd1] <= in_bit;
        bit_cnt            <= bit_cnt + 3'd1;
      end
    end
  end

  // Output register: a completing frame reloads even while draining
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data     <= '0;
      out_syndrome <= '0;
      out_err      <= 1'b0;
      out_valid    <= 1'b0;
    end else if (done) begin
      out_data     <= fix_data;
      out_syndrome <= fix_syn;
      out_err      <= (fix_syn != 3'd0);
      out_valid    <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // Corrected-frame counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= '0;
    end else if (done && fix_syn != 3'd0 && err_count != '1) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_rx_corrector.sv
// Directed self-checking bench for hamming_rx_corrector (CNT_W=2 so the
// counter saturates at 3).
module tb_hamming_rx_corrector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_bit, in_valid, in_sof, in_ready;
  logic [3:0] out_data;
  logic [2:0] out_syndrome;
  logic       out_err, out_valid, out_ready, clr_count;
  logic [1:0] err_count;

  int checks = 0;
  int errors = 0;
  logic pre7_valid;

  // Codewords stored [7:1], position 1 transmitted first
  localparam logic [7:1] CW_B_CLEAN = 7'b1010101; // 0xB
  localparam logic [7:1] CW_B_POS5  = 7'b1000101; // 0xB, position 5 flipped
  localparam logic [7:1] CW_B_POS4  = 7'b1011101; // 0xB, position 4 flipped
  localparam logic [7:1] CW_ZERO    = 7'b0000000; // 0x0
  localparam logic [7:1] CW_5_CLEAN = 7'b0101101; // 0x5
  localparam logic [7:1] CW_5_POS3  = 7'b0101001; // 0x5, position 3 flipped

  hamming_rx_corrector #(.CNT_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_bit       (in_bit),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_syndrome (out_syndrome),
    .out_err      (out_err),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .clr_count    (clr_count),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic b, input logic sof);
    in_bit   = b;
    in_sof   = sof;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // Sends positions 1..7, sof on the first; optional clear on the last beat.
  task automatic send_frame(input logic [7:1] cw, input logic clr_last);
    logic [7:1] w;
    w = cw;
    for (int unsigned i = 1; i <= 7; i++) begin
      in_bit    = w[i];
      in_sof    = (i == 1);
      in_valid  = 1'b1;
      clr_count = clr_last && (i == 7);
      if (i == 7) pre7_valid = out_valid;
      tick();
    end
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    clr_count = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    out_ready = 1'b1; clr_count = 1'b0; pre7_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_syn", out_syndrome, 0);
    check("rst_err", out_err, 0);
    check("rst_cnt", err_count, 0);
    check("rst_ready", in_ready, 1);

    // Clean frame
    send_frame(CW_B_CLEAN, 1'b0);
    check("clean_pre7_valid", pre7_valid, 0);
    check("clean_valid", out_valid, 1);
    check("clean_data", out_data, 4'hB);
    check("clean_syn", out_syndrome, 3'b000);
    check("clean_err", out_err, 0);
    check("clean_cnt", err_count, 0);
    tick();
    check("clean_drained", out_valid, 0);

    // Data-bit error
    send_frame(CW_B_POS5, 1'b0);
    check("d_err_data", out_data, 4'hB);
    check("d_err_syn", out_syndrome, 3'b101);
    check("d_err_err", out_err, 1);
    check("d_err_cnt", err_count, 1);
    tick();

    // Parity-bit error
    send_frame(CW_B_POS4, 1'b0);
    check("p_err_data", out_data, 4'hB);
    check("p_err_syn", out_syndrome, 3'b100);
    check("p_err_err", out_err, 1);
    check("p_err_cnt", err_count, 2);
    tick();

    // Back-pressure: two frames with out_ready low
    out_ready = 1'b0;
    send_frame(CW_B_CLEAN, 1'b0);
    check("bp_first_valid", out_valid, 1);
    check("bp_first_data", out_data, 4'hB);
    beat(1'b0, 1'b1);
    for (int unsigned i = 2; i <= 6; i++) beat(1'b0, 1'b0);
    check("bp_ready_pre7", in_ready, 0);
    in_bit = 1'b0; in_sof = 1'b0; in_valid = 1'b1;
    #1;
    check("bp_stall_ready", in_ready, 0);
    tick();
    check("bp_hold_data0", out_data, 4'hB);
    check("bp_hold_valid0", out_valid, 1);
    tick();
    check("bp_hold_data1", out_data, 4'hB);
    check("bp_hold_ready1", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    check("bp_deliver_first", out_data, 4'hB);
    tick();
    in_valid = 1'b0;
    check("bp_second_valid", out_valid, 1);
    check("bp_second_data", out_data, 4'h0);
    check("bp_second_syn", out_syndrome, 3'b000);
    tick();
    check("bp_drained", out_valid, 0);
    check("bp_cnt", err_count, 2);

    // Restart: sof on the 4th bit begins a new frame
    beat(1'b1, 1'b1); beat(1'b0, 1'b0); beat(1'b1, 1'b0);
    send_frame(CW_5_CLEAN, 1'b0);
    check("rs_pre7_valid", pre7_valid, 0);
    check("rs_valid", out_valid, 1);
    check("rs_data", out_data, 4'h5);
    check("rs_syn", out_syndrome, 3'b000);
    tick();

    // Reset mid-frame with an undelivered output pending
    out_ready = 1'b0;
    send_frame(CW_B_POS4, 1'b0);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_cnt", err_count, 3);
    beat(1'b1, 1'b1); beat(1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_syn", out_syndrome, 0);
    check("mid_rst_err", out_err, 0);
    check("mid_rst_cnt", err_count, 0);
    check("mid_rst_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 5; i++) beat(1'b1, 1'b0);
    check("post_rst_no_frame", out_valid, 0);
    send_frame(CW_5_POS3, 1'b0);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 4'h5);
    check("post_rst_syn", out_syndrome, 3'b011);
    check("post_rst_err", out_err, 1);
    check("post_rst_cnt", err_count, 1);
    tick();

    // Counter: clear, saturate, clear-vs-increment priority
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("clr_cnt", err_count, 0);
    send_frame(CW_B_POS5, 1'b0); check("sat_cnt1", err_count, 1);
    send_frame(CW_B_POS5, 1'b0); check("sat_cnt2", err_count, 2);
    send_frame(CW_B_POS5, 1'b0); check("sat_cnt3", err_count, 3);
    send_frame(CW_B_POS5, 1'b0); check("sat_cnt4", err_count, 3);
    send_frame(CW_B_POS5, 1'b0); check("sat_cnt5", err_count, 3);
    send_frame(CW_B_POS5, 1'b1);
    check("clr_prio_valid", out_valid, 1);
    check("clr_prio_cnt", err_count, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_rx_corrector.md
# hamming_rx_corrector

Serial Hamming(7,4) receive stage that sits directly downstream of the team's 4-bit Hamming parity generator and its serializer. It does five things:
- shifts in one 7-bit codeword per frame, one bit per accepted beat;
- computes the 3-bit syndrome;
- corrects any single-bit error;
- presents the corrected nibble on a valid/ready output register;
- keeps a saturating count of corrected frames.

## Interface
- CNT_W, 8, width of the corrected-frame counter
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_bit  input  1  serial codeword bit
- in_valid  input  1  in_bit is valid this cycle
- in_sof  input  1  qualifies in_bit as codeword position 1 (start of frame)
- in_ready  output  1  block accepts in_bit this cycle
- out_data  output  4  corrected nibble {m3,m2,m1,m0}
- out_syndrome  output  3  {s3,s2,s1} of the delivered frame
- out_err  output  1  syndrome was non-zero, so a correction was applied
- out_valid  output  1  out_* fields hold an undelivered frame
- out_ready  input  1  consumer accepts the output
- clr_count  input  1  synchronous clear of err_count
- err_count  output  CNT_W  saturating count of frames with out_err=1

## Operation
- Beat = in_valid && in_ready.
- Codeword positions 1..7 = P1, P2, m0, P3, m1, m2, m3. Position 1 is transmitted first.
- Parity equations, matching the encoder:
  - P1 = m0^m1^m3
  - P2 = m0^m2^m3
  - P3 = m1^m2^m3
- Syndrome:
  - s1 = c1^c3^c5^c7
  - s2 = c2^c3^c6^c7
  - s3 = c4^c5^c6^c7
- A non-zero syndrome names the position to invert. If that position is a parity bit, the data is unchanged. Double errors are miscorrected; this is by design and no detection is provided.
- FSM states:
  - IDLE: accept beats and discard them until a beat with in_sof=1 arrives. That beat is stored as position 1, bit_cnt=1, go to SHIFT.
  - SHIFT: each beat stores the next position. A beat with in_sof=1 aborts the partial frame, is stored as position 1, and sets bit_cnt=1. The beat that completes position 7 loads the output register and returns to IDLE.
- Output register:
  - On frame completion, load out_data, out_syndrome and out_err, and set out_valid=1.
  - Clear out_valid on out_valid && out_ready, unless a new frame completes in the same cycle. In that case the register reloads and out_valid stays 1.
- Back-pressure: in_ready = !(state==SHIFT && bit_cnt==6 && out_valid && !out_ready). Only the completing beat stalls.
- err_count increments by 1 on each frame load with out_err=1 and saturates at 2^CNT_W-1.
- clr_count has priority: if a clear and an increment happen in the same cycle, the count ends at 0.

## Timing
- Reset values: state=IDLE, bit_cnt=0, shift register=0, out_data=0, out_syndrome=0, out_err=0, out_valid=0, err_count=0, in_ready=1.
- Reset mid-frame discards the partial frame and any undelivered output.
- Latency: the 7th beat is accepted in cycle N; out_valid=1 with corrected data is visible in cycle N+1.
- Throughput: one nibble per 7 beats with no bubbles while out_ready=1.
- The output holds stable while out_valid=1 && out_ready=0.
- The syndrome and correction logic are combinational on the completed codeword, including the 7th bit. They are registered only in the output stage.
- in_sof on the 7th beat is treated as a restart, not as completion.

## Structure
- Package hamming_pkg holds:
  - position constants POS_P1..POS_M3 (1..7);
  - typedef codeword_t (logic [7:1]);
  - typedef nibble_t (logic [3:0]);
  - state enum rx_state_t {IDLE, SHIFT}.
- Sub-module hamming_syndrome_fix: purely combinational; codeword_t in, nibble_t data and 3-bit syndrome out.
- The top level holds the FSM, the shift register, the output register and the counter.

## Test plan
- Clean frame: data 0xB, serial 1,0,1,0,1,0,1 (sof on the first bit), out_ready=1. Require out_data=0xB, out_syndrome=0, out_err=0, out_valid exactly 1 cycle after the 7th beat, err_count=0.
- Data error: the same frame with position 5 flipped (1,0,1,0,0,0,1). Require out_data=0xB, out_syndrome=3'b101, out_err=1, err_count=1.
- Parity error: position 4 flipped (1,0,1,1,1,0,1). Require out_data=0xB, out_syndrome=3'b100, out_err=1.
- Back-pressure:
  - Stimulus: hold out_ready=0 and stream two back-to-back frames, 0xB then all-zero.
  - Require in_ready=0 on the second frame's 7th bit, with the first output held stable.
  - Raising out_ready delivers 0xB, then 0x0 one cycle later.
- Restart and reset:
  - Assert in_sof on the 4th bit of a frame; the next 7 beats form the delivered frame.
  - Deassert rst_n for 1 cycle mid-frame; all outputs return to their reset values and the next sof frame decodes correctly.
- Counter: CNT_W=2 with 5 error frames gives err_count=3 (saturated). clr_count asserted in the same cycle as an error-frame load gives err_count=0.
